regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Write-back controller for the core's 32x32 register file. It shares the register file's single write port between two write-back requesters, EXU and LSU, and registers the winning write onto the port. It also keeps a busy scoreboard of registers with writes in flight, so decode can stall on RAW/WAW hazards. It sits between IDU/EXU/LSU and the register file write port (wen/waddr/wdata).

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width; number of registers = 2**ADDR_W
CNT_W, 6, width of pending_cnt; must hold 2**ADDR_W - 1

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode issues an instruction that will write issue_rd
issue_rd  in  ADDR_W  destination register of issuing instruction
issue_ready  out  1  issue accepted this cycle
rs1_addr  in  ADDR_W  decode source 1 address
rs2_addr  in  ADDR_W  decode source 2 address
rs1_busy  out  1  rs1 has a write in flight (combinational)
rs2_busy  out  1  rs2 has a write in flight (combinational)
exu_valid  in  1  EXU write-back request
exu_rd  in  ADDR_W  EXU destination
exu_data  in  DATA_W  EXU result
exu_ready  out  1  EXU request granted
lsu_valid  in  1  LSU write-back request
lsu_rd  in  ADDR_W  LSU destination
lsu_data  in  DATA_W  LSU load data
lsu_ready  out  1  LSU request granted
rf_wen  out  1  register file write enable (registered)
rf_waddr  out  ADDR_W  register file write address (registered)
rf_wdata  out  DATA_W  register file write data (registered)
pending_cnt  out  CNT_W  number of busy registers
wb_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async, rst_n=0): busy[] all 0, rf_wen=0, rf_waddr=0, rf_wdata=0, pending_cnt=0, wb_err=0, RR pointer to "LSU next". All outputs hold these values while rst_n=0. In-flight writes are dropped.
- Scoreboard: busy[ADDR_W-bit index], busy[0] hardwired 0.
  - rsN_busy = busy[rsN_addr]. An address of 0 is never busy.
- Issue:
  - issue_ready = !busy[issue_rd]. This forbids WAW: a second writer to the same rd stalls.
  - On issue_valid && issue_ready && issue_rd!=0, busy[issue_rd] is set at the next edge.
  - issue_rd=0 is always accepted and marks nothing.
- Write-back handshake:
  - A request transfers when valid && ready.
  - The requester holds valid, rd and data stable until ready.
  - At most one grant per cycle.
  - ready is combinational from both valids; it never depends on ready.
- Arbitration: fixed priority, LSU over EXU. The default and RR variant are described under Optional Feature.
- Write port, 1-cycle latency: on a grant, at the next edge rf_wen=(rd!=0), rf_waddr=rd, rf_wdata=data. With no grant, rf_wen=0 next cycle and waddr/wdata hold their values.
- Busy clear:
  - At the edge where rf_wen=1 is presented, busy[rf_waddr] is cleared. The register file captures the data on that same edge.
  - rsN_busy therefore drops on the first cycle in which the register file read returns new data. No bypass is needed.
- Set/clear on the same register in the same cycle cannot occur, because issue_ready=0 while busy.
- pending_cnt: +1 on set, -1 on clear, unchanged when both or neither happen. It always equals popcount(busy).
- Write-back error:
  - A granted rd!=0 with busy[rd]=0 sets wb_err, which stays set until reset.
  - The write is still performed.
- Back-to-back grants every cycle are supported. Throughput is 1 write per cycle.

Optional Feature:
RF_WB_RR_EN
- Defined: round-robin arbitration. When both valid, grant the requester not granted most recently. The pointer updates only on a contended or uncontended grant to point away from the winner. After reset it points to LSU.
- Undefined: fixed priority, LSU always wins. EXU can starve while LSU stays valid.

Test Plan:
- Reset mid-write: issue rd=5, LSU grant, assert rst_n=0 the cycle rf_wen=1 -> rf_wen=0 immediately, busy[5]=0, pending_cnt=0.
- Basic: issue rd=7, then exu_valid rd=7 data=0xDEADBEEF -> exu_ready=1 same cycle; next cycle rf_wen=1/waddr=7/wdata=0xDEADBEEF; rs1_addr=7 busy until the cycle after; pending_cnt 1->0.
- Contention: issue rd=3 and rd=4; EXU(3,0x11) and LSU(4,0x22) both valid -> LSU granted first, EXU next cycle. With RF_WB_RR_EN, two further contended rounds alternate EXU/LSU.
- WAW stall: busy[9]=1, issue rd=9 -> issue_ready=0 until the cycle after the rd=9 write, then 1.
- x0: issue rd=0 -> pending_cnt unchanged. EXU write rd=0 data=0x5 -> exu_ready=1, rf_wen stays 0, rs1_busy for addr 0 always 0.
- Error: EXU write rd=12 without prior issue -> write performed (rf_wen=1, waddr=12), wb_err=1 and sticky until reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file write port plus the busy scoreboard used by decode.
// Define RF_WB_RR_EN for round-robin EXU/LSU arbitration; otherwise LSU has fixed priority.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  input  logic              exu_valid,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  output logic              exu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [CNT_W-1:0]  pending_cnt,
  output logic              wb_err
);

  localparam int NREG = 2**ADDR_W;

  // x0 never gets a flop: its busy bit is a constant zero spliced in below.
  logic [NREG-1:1]   busy_q, busy_d;
  logic [NREG-1:0]   busy_vec, busy_nxt;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [CNT_W-1:0]  pending_cnt_q, pending_cnt_d;
  logic              wb_err_q, wb_err_d;

  logic              gnt_exu, gnt_lsu, gnt_any;
  logic [ADDR_W-1:0] gnt_rd;
  logic [DATA_W-1:0] gnt_data;
  logic              issue_fire, clr_hit;

  assign busy_vec = {busy_q, 1'b0};

  assign rs1_busy    = busy_vec[rs1_addr];
  assign rs2_busy    = busy_vec[rs2_addr];
  assign issue_ready = ~busy_vec[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != '0);

`ifdef RF_WB_RR_EN
  logic rr_lsu_next_q, rr_lsu_next_d;

  // On contention, the side that did not win most recently goes first.
  assign gnt_lsu = lsu_valid && (!exu_valid || rr_lsu_next_q);

  always_comb begin
    rr_lsu_next_d = rr_lsu_next_q;
    if (gnt_lsu)      rr_lsu_next_d = 1'b0;
    else if (gnt_exu) rr_lsu_next_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_lsu_next_q <= 1'b1;
    else        rr_lsu_next_q <= rr_lsu_next_d;
  end
`else
  assign gnt_lsu = lsu_valid;
`endif

  assign gnt_exu   = exu_valid && !gnt_lsu;
  assign gnt_any   = gnt_exu || gnt_lsu;
  assign gnt_rd    = gnt_lsu ? lsu_rd : exu_rd;
  assign gnt_data  = gnt_lsu ? lsu_data : exu_data;
  assign exu_ready = gnt_exu;
  assign lsu_ready = gnt_lsu;

  // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
  always_comb begin
    busy_nxt = busy_vec;
    clr_hit  = 1'b0;
    if (rf_wen_q) begin
      clr_hit              = busy_vec[rf_waddr_q];
      busy_nxt[rf_waddr_q] = 1'b0;
    end
    if (issue_fire) busy_nxt[issue_rd] = 1'b1;
    busy_d = busy_nxt[NREG-1:1];

    // A real clear never coincides with a set: that register still blocks issue.
    unique case ({issue_fire, clr_hit})
      2'b10:   pending_cnt_d = pending_cnt_q + CNT_W'(1);
      2'b01:   pending_cnt_d = pending_cnt_q - CNT_W'(1);
      default: pending_cnt_d = pending_cnt_q;
    endcase
  end

  always_comb begin
    rf_wen_d   = gnt_any && (gnt_rd != '0);
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    wb_err_d   = wb_err_q;
    if (gnt_any) begin
      rf_waddr_d = gnt_rd;
      rf_wdata_d = gnt_data;
      if ((gnt_rd != '0) && !busy_vec[gnt_rd]) wb_err_d = 1'b1;
    end
  end

  // NOTE: the scoreboard is control state and must be reset, unlike a plain data array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= '0;
      rf_wen_q      <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      pending_cnt_q <= '0;
      wb_err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      busy_q        <= busy_d;
      rf_wen_q      <= rf_wen_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      pending_cnt_q <= pending_cnt_d;
      wb_err_q      <= wb_err_d;
    end
  end

  assign rf_wen      = rf_wen_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign pending_cnt = pending_cnt_q;
  assign wb_err      = wb_err_q;

  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_exu && gnt_lsu));
  a_cnt_popcount: assert property (@(posedge clk) disable iff (!rst_n)
    pending_cnt_q == CNT_W'($countones(busy_vec)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios with literal expectations, then random traffic
// checked every cycle against a behavioural scoreboard model.
module tb_regfile_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;
  localparam int NREG   = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic [ADDR_W-1:0] issue_rd = '0;
  logic              issue_ready;
  logic [ADDR_W-1:0] rs1_addr = '0, rs2_addr = '0;
  logic              rs1_busy, rs2_busy;
  logic              exu_valid = 1'b0;
  logic [ADDR_W-1:0] exu_rd = '0;
  logic [DATA_W-1:0] exu_data = '0;
  logic              exu_ready;
  logic              lsu_valid = 1'b0;
  logic [ADDR_W-1:0] lsu_rd = '0;
  logic [DATA_W-1:0] lsu_data = '0;
  logic              lsu_ready;
  logic              rf_wen;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [CNT_W-1:0]  pending_cnt;
  logic              wb_err;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pending_cnt(pending_cnt), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a set of registers awaiting write-back and the last write presented.
  typedef enum {W_EXU, W_LSU} who_e;
  bit          m_busy [NREG];
  who_e        m_last_winner;
  bit          m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          m_err;
  bit          m_issue_fired, m_gnt_exu, m_gnt_lsu;
  logic [4:0]  m_issue_rd;

  function automatic bit lsu_wins();
    bit prefer_lsu;
`ifdef RF_WB_RR_EN
    prefer_lsu = (m_last_winner != W_LSU);
`else
    prefer_lsu = 1'b1;
`endif
    return lsu_valid && (!exu_valid || prefer_lsu);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_last_winner = W_EXU;
      m_wen = 1'b0; m_waddr = '0; m_wdata = '0; m_err = 1'b0;
      m_issue_fired = 1'b0; m_gnt_exu = 1'b0; m_gnt_lsu = 1'b0; m_issue_rd = '0;
    end else begin
      bit gl, ge, fire;
      logic [4:0]  rd;
      logic [31:0] d;
      gl   = lsu_wins();
      ge   = exu_valid && !gl;
      fire = issue_valid && !m_busy[issue_rd];
      rd   = gl ? lsu_rd : exu_rd;
      d    = gl ? lsu_data : exu_data;
      if ((gl || ge) && rd != 0 && !m_busy[rd]) m_err = 1'b1;
      if (m_wen) m_busy[m_waddr] = 1'b0;
      if (fire && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      m_wen = (gl || ge) && rd != 0;
      if (gl || ge) begin
        m_waddr = rd;
        m_wdata = d;
        m_last_winner = gl ? W_LSU : W_EXU;
      end
      m_issue_fired = fire; m_issue_rd = issue_rd;
      m_gnt_exu = ge; m_gnt_lsu = gl;
    end
  end

  always @(negedge clk) begin
    int cnt;
    bit gl;
    cnt = 0;
    foreach (m_busy[i]) cnt += int'(m_busy[i]);
    gl = lsu_wins();
    check("cmp_issue_ready", issue_ready, !m_busy[issue_rd]);
    check("cmp_rs1_busy", rs1_busy, m_busy[rs1_addr]);
    check("cmp_rs2_busy", rs2_busy, m_busy[rs2_addr]);
    check("cmp_lsu_ready", lsu_ready, gl);
    check("cmp_exu_ready", exu_ready, exu_valid && !gl);
    check("cmp_rf_wen", rf_wen, m_wen);
    check("cmp_rf_waddr", rf_waddr, m_waddr);
    check("cmp_rf_wdata", rf_wdata, m_wdata);
    check("cmp_pending_cnt", pending_cnt, cnt);
    check("cmp_wb_err", wb_err, m_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    exu_valid   = 1'b0;
    lsu_valid   = 1'b0;
  endtask

  logic [4:0]  exu_pool[$], lsu_pool[$];
  bit          exu_hold = 1'b0, lsu_hold = 1'b0;

  task automatic rand_cycle(input bit allow_issue);
    if (m_issue_fired) begin
      if ($urandom_range(1) == 1) exu_pool.push_back(m_issue_rd);
      else                        lsu_pool.push_back(m_issue_rd);
    end
    if (m_gnt_exu) exu_hold = 1'b0;
    if (m_gnt_lsu) lsu_hold = 1'b0;
    if (!exu_hold && exu_pool.size() != 0 && $urandom_range(3) != 0) begin
      exu_hold = 1'b1; exu_rd = exu_pool.pop_front(); exu_data = $urandom;
    end
    if (!lsu_hold && lsu_pool.size() != 0 && $urandom_range(3) != 0) begin
      lsu_hold = 1'b1; lsu_rd = lsu_pool.pop_front(); lsu_data = $urandom;
    end
    exu_valid   = exu_hold;
    lsu_valid   = lsu_hold;
    issue_valid = allow_issue && ($urandom_range(1) == 1);
    issue_rd    = 5'($urandom_range(31));
    rs1_addr    = 5'($urandom_range(31));
    rs2_addr    = 5'($urandom_range(31));
  endtask

  logic [4:0]  e_rd [2];
  logic [31:0] e_d  [2];
  logic [4:0]  l_rd [2];
  logic [31:0] l_d  [2];
  bit          exp_l [4];

  initial begin
    int ei, li, guard;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_rf_wen", rf_wen, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_pending", pending_cnt, 0);
    check("rst_wb_err", wb_err, 0);

    // Basic EXU write-back of rd=7
    tick(); issue_valid = 1; issue_rd = 7; rs1_addr = 7; #1;
    check("basic_issue_ready", issue_ready, 1);
    check("basic_rs1_pre", rs1_busy, 0);
    tick(); issue_valid = 0; exu_valid = 1; exu_rd = 7; exu_data = 32'hDEADBEEF; #1;
    check("basic_exu_ready", exu_ready, 1);
    check("basic_rs1_busy", rs1_busy, 1);
    check("basic_pending1", pending_cnt, 1);
    tick(); exu_valid = 0; #1;
    check("basic_rf_wen", rf_wen, 1);
    check("basic_rf_waddr", rf_waddr, 7);
    check("basic_rf_wdata", rf_wdata, 32'hDEADBEEF);
    check("basic_rs1_still", rs1_busy, 1);
    tick(); #1;
    check("basic_rf_wen_off", rf_wen, 0);
    check("basic_rs1_clear", rs1_busy, 0);
    check("basic_pending0", pending_cnt, 0);
    check("basic_wdata_hold", rf_wdata, 32'hDEADBEEF);

    // Contention: EXU holds rd 3 then 10, LSU holds rd 4 then 11, both kept valid
    e_rd[0] = 3;  e_d[0] = 32'h11; e_rd[1] = 10; e_d[1] = 32'h33;
    l_rd[0] = 4;  l_d[0] = 32'h22; l_rd[1] = 11; l_d[1] = 32'h44;
`ifdef RF_WB_RR_EN
    exp_l[0] = 1; exp_l[1] = 0; exp_l[2] = 1; exp_l[3] = 0;
`else
    exp_l[0] = 1; exp_l[1] = 1; exp_l[2] = 0; exp_l[3] = 0;
`endif
    tick(); issue_valid = 1; issue_rd = 3;
    tick(); issue_rd = 4;
    tick(); issue_rd = 10;
    tick(); issue_rd = 11;
    tick(); issue_valid = 0;
    ei = 0; li = 0;
    for (int c = 0; c < 4; c++) begin
      exu_valid = (ei < 2);
      if (ei < 2) begin exu_rd = e_rd[ei]; exu_data = e_d[ei]; end
      lsu_valid = (li < 2);
      if (li < 2) begin lsu_rd = l_rd[li]; lsu_data = l_d[li]; end
      #1;
      check("cont_lsu_ready", lsu_ready, exp_l[c]);
      check("cont_exu_ready", exu_ready, !exp_l[c]);
      if (exp_l[c]) li++; else ei++;
      tick();
    end
    idle(); #1;
    check("cont_last_waddr", rf_waddr, exp_l[3] ? 11 : 10);
    repeat (3) tick();
    #1 check("cont_pending0", pending_cnt, 0);

    // WAW stall on rd 9
    tick(); issue_valid = 1; issue_rd = 9; #1;
    check("waw_first_ready", issue_ready, 1);
    tick(); #1;
    check("waw_stall", issue_ready, 0);
    tick(); exu_valid = 1; exu_rd = 9; exu_data = 32'h99; #1;
    check("waw_stall_wb", issue_ready, 0);
    check("waw_exu_ready", exu_ready, 1);
    tick(); exu_valid = 0; #1;
    check("waw_rf_wen", rf_wen, 1);
    check("waw_stall_presented", issue_ready, 0);
    tick(); issue_valid = 0; #1;
    check("waw_released", issue_ready, 1);

    // x0 handling
    tick(); issue_valid = 1; issue_rd = 0; rs1_addr = 0; #1;
    check("x0_issue_ready", issue_ready, 1);
    check("x0_rs1_busy", rs1_busy, 0);
    tick(); issue_valid = 0; exu_valid = 1; exu_rd = 0; exu_data = 32'h5; #1;
    check("x0_pending", pending_cnt, 0);
    check("x0_exu_ready", exu_ready, 1);
    tick(); exu_valid = 0; #1;
    check("x0_rf_wen", rf_wen, 0);
    check("x0_wb_err", wb_err, 0);
    check("x0_rs1_busy2", rs1_busy, 0);

    // Reset while a write is presented
    tick(); issue_valid = 1; issue_rd = 5; rs1_addr = 5;
    tick(); issue_valid = 0; lsu_valid = 1; lsu_rd = 5; lsu_data = 32'h55; #1;
    check("rstw_lsu_ready", lsu_ready, 1);
    tick(); lsu_valid = 0; #1;
    check("rstw_rf_wen_pre", rf_wen, 1);
    rst_n = 1'b0; #1;
    check("rstw_rf_wen", rf_wen, 0);
    check("rstw_rs1_busy", rs1_busy, 0);
    check("rstw_pending", pending_cnt, 0);
    check("rstw_waddr", rf_waddr, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Random traffic obeying the issue/write-back protocol
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rand_cycle(1'b1);
    end
    guard = 0;
    do begin
      tick();
      rand_cycle(1'b0);
      guard++;
    end while ((exu_pool.size() != 0 || lsu_pool.size() != 0 || exu_hold || lsu_hold) && guard < 400);
    check("rand_drain_in_budget", guard < 400, 1);
    idle();
    repeat (3) tick();
    #1;
    check("rand_pending0", pending_cnt, 0);
    check("rand_no_err", wb_err, 0);

    // Write-back to a register that was never issued
    tick(); exu_valid = 1; exu_rd = 12; exu_data = 32'hC0FFEE; #1;
    check("err_exu_ready", exu_ready, 1);
    check("err_pre", wb_err, 0);
    tick(); exu_valid = 0; #1;
    check("err_rf_wen", rf_wen, 1);
    check("err_rf_waddr", rf_waddr, 12);
    check("err_set", wb_err, 1);
    repeat (3) tick();
    #1;
    check("err_sticky", wb_err, 1);
    check("err_pending", pending_cnt, 0);
    rst_n = 1'b0; #1;
    check("err_reset", wb_err, 0);
    tick(); rst_n = 1'b1;
    repeat (2) tick();
    #1 check("err_after_reset", wb_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
